// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared definitions for the SDRAM burst arbiter: FSM states, grant bit
// positions and the default write-starvation threshold.
package sdram_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_WR    = 2'd1,
    GNT_RD    = 2'd2,
    ZERO_DONE = 2'd3
  } arb_state_e;

  localparam int unsigned GNT_WR_BIT          = 0;
  localparam int unsigned GNT_RD_BIT          = 1;
  localparam int unsigned WR_WAIT_MAX_DEFAULT = 64;

endpackage

// File: rtl/sdram_burst_arbiter.sv
// Two-requester (write/read) burst arbiter in front of an SDRAM controller.
// Read has fixed priority on a tie. Defining ARB_STARVE_GUARD_EN adds a
// saturating wait counter that lets a starved write win ties once it has
// waited WR_WAIT_MAX cycles.
// Zero-length bursts are never forwarded; they are finished locally via
// the ZERO_DONE state.
module sdram_burst_arbiter
  import sdram_burst_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned BUSRT_BITS    = 10,
  parameter int unsigned MEM_DATA_BITS = 16,
  parameter int unsigned WR_WAIT_MAX   = WR_WAIT_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // write requester
  input  logic                     wr_req,
  input  logic [BUSRT_BITS-1:0]    wr_len,
  input  logic [ADDR_BITS-1:0]     wr_addr,
  input  logic [MEM_DATA_BITS-1:0] wr_data,
  output logic                     wr_data_req,
  output logic                     wr_finish,
  // read requester
  input  logic                     rd_req,
  input  logic [BUSRT_BITS-1:0]    rd_len,
  input  logic [ADDR_BITS-1:0]     rd_addr,
  output logic                     rd_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_data,
  output logic                     rd_finish,
  // controller write side
  output logic                     mem_wr_burst_req,
  output logic [BUSRT_BITS-1:0]    mem_wr_burst_len,
  output logic [ADDR_BITS-1:0]     mem_wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0] mem_wr_burst_data,
  input  logic                     mem_wr_burst_data_req,
  input  logic                     mem_wr_burst_finish,
  // controller read side
  output logic                     mem_rd_burst_req,
  output logic [BUSRT_BITS-1:0]    mem_rd_burst_len,
  output logic [ADDR_BITS-1:0]     mem_rd_burst_addr,
  input  logic                     mem_rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_burst_data,
  input  logic                     mem_rd_burst_finish,
  // ownership
  output logic [1:0]               grant
);

  arb_state_e              state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic [BUSRT_BITS-1:0]   len_q, len_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic                    wr_first;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(WR_WAIT_MAX + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Saturating count of cycles a write request sits ungranted
  always_comb begin
    wait_d = wait_q;
    if (grant_q[GNT_WR_BIT]) begin
      wait_d = '0;
    end else if (wr_req && (wait_q < WAIT_W'(WR_WAIT_MAX))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wr_first = wr_req && (wait_q >= WAIT_W'(WR_WAIT_MAX));
`else
  assign wr_first = 1'b0;
`endif

  // State, owner and captured burst descriptor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
    end
  end

  // Arbitration and burst sequencing
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req && !wr_first) begin
          state_d             = GNT_RD;
          grant_d             = '0;
          grant_d[GNT_RD_BIT] = 1'b1;
          len_d               = rd_len;
          addr_d              = rd_addr;
        end else if (wr_req) begin
          state_d             = GNT_WR;
          grant_d             = '0;
          grant_d[GNT_WR_BIT] = 1'b1;
          len_d               = wr_len;
          addr_d              = wr_addr;
        end
      end
      GNT_WR: begin
        if (len_q == '0) begin
          state_d = ZERO_DONE;
        end else if (mem_wr_burst_finish) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      GNT_RD: begin
        if (len_q == '0) begin
          state_d = ZERO_DONE;
        end else if (mem_rd_burst_finish) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      ZERO_DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant             = grant_q;
  assign mem_wr_burst_req  = (state_q == GNT_WR) && (len_q != '0);
  assign mem_rd_burst_req  = (state_q == GNT_RD) && (len_q != '0);
  assign mem_wr_burst_len  = len_q;
  assign mem_wr_burst_addr = addr_q;
  assign mem_rd_burst_len  = len_q;
  assign mem_rd_burst_addr = addr_q;
  assign mem_wr_burst_data = wr_data;
  assign rd_data           = mem_rd_burst_data;
  assign wr_data_req       = mem_wr_burst_data_req & grant_q[GNT_WR_BIT];
  assign rd_data_valid     = mem_rd_burst_data_valid & grant_q[GNT_RD_BIT];
  // Forwarded bursts finish on the controller strobe; zero-length ones finish
  // in ZERO_DONE on whichever side still holds the grant.
  assign wr_finish = ((state_q == ZERO_DONE) && grant_q[GNT_WR_BIT]) ||
                     (mem_wr_burst_req && mem_wr_burst_finish);
  assign rd_finish = ((state_q == ZERO_DONE) && grant_q[GNT_RD_BIT]) ||
                     (mem_rd_burst_req && mem_rd_burst_finish);

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: transaction-level owner model,
// randomized requesters and a randomized memory-controller stub, plus
// directed scenarios with literal expectations.
module tb_sdram_burst_arbiter;

  localparam int AW = 24;
  localparam int LW = 10;
  localparam int DW = 16;
`ifdef ARB_STARVE_GUARD_EN
  localparam int WMAX  = 4;
  localparam bit GUARD = 1'b1;
`else
  localparam int WMAX  = 64;
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [LW-1:0] wr_len = '0, rd_len = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_req, wr_finish, rd_data_valid, rd_finish;
  logic [DW-1:0] rd_data, mem_wr_burst_data;
  logic          mem_wr_burst_req, mem_rd_burst_req;
  logic [LW-1:0] mem_wr_burst_len, mem_rd_burst_len;
  logic [AW-1:0] mem_wr_burst_addr, mem_rd_burst_addr;
  logic          mem_wr_burst_data_req = 1'b0, mem_wr_burst_finish = 1'b0;
  logic          mem_rd_burst_data_valid = 1'b0, mem_rd_burst_finish = 1'b0;
  logic [DW-1:0] mem_rd_burst_data = '0;
  logic [1:0]    grant;

  sdram_burst_arbiter #(
    .ADDR_BITS(AW), .BUSRT_BITS(LW), .MEM_DATA_BITS(DW), .WR_WAIT_MAX(WMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_len(wr_len), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_data_req(wr_data_req), .wr_finish(wr_finish),
    .rd_req(rd_req), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_finish(rd_finish),
    .mem_wr_burst_req(mem_wr_burst_req), .mem_wr_burst_len(mem_wr_burst_len),
    .mem_wr_burst_addr(mem_wr_burst_addr), .mem_wr_burst_data(mem_wr_burst_data),
    .mem_wr_burst_data_req(mem_wr_burst_data_req),
    .mem_wr_burst_finish(mem_wr_burst_finish),
    .mem_rd_burst_req(mem_rd_burst_req), .mem_rd_burst_len(mem_rd_burst_len),
    .mem_rd_burst_addr(mem_rd_burst_addr),
    .mem_rd_burst_data_valid(mem_rd_burst_data_valid),
    .mem_rd_burst_data(mem_rd_burst_data),
    .mem_rd_burst_finish(mem_rd_burst_finish),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  bit force_wfin = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 write, 2 read. A zero-length grant spends one cycle
  // as owner with nothing forwarded, then one "local finish" cycle.
  int            m_owner = 0;
  bit            m_local_fin = 1'b0;
  logic [LW-1:0] m_len = '0;
  logic [AW-1:0] m_addr = '0;
  int            m_wait = 0;
  int            m_prev_owner;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_local_fin = 1'b0; m_len = '0; m_addr = '0; m_wait = 0;
    end else begin
      m_prev_owner = m_owner;
      if (m_owner == 0) begin
        if (rd_req && !(GUARD && wr_req && m_wait >= WMAX)) begin
          m_owner = 2; m_len = rd_len; m_addr = rd_addr;
        end else if (wr_req) begin
          m_owner = 1; m_len = wr_len; m_addr = wr_addr;
        end
      end else if (m_local_fin) begin
        m_owner = 0; m_local_fin = 1'b0;
      end else if (m_len == 0) begin
        m_local_fin = 1'b1;
      end else if ((m_owner == 1 && mem_wr_burst_finish) ||
                   (m_owner == 2 && mem_rd_burst_finish)) begin
        m_owner = 0;
      end
      if (m_prev_owner == 1) m_wait = 0;
      else if (wr_req && m_wait < WMAX) m_wait++;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic ew, er;
      ew = (m_owner == 1) && !m_local_fin && (m_len != 0);
      er = (m_owner == 2) && !m_local_fin && (m_len != 0);
      chk("grant", 32'(grant), (m_owner == 1) ? 32'd1 : (m_owner == 2) ? 32'd2 : 32'd0);
      chk("mem_wr_req", 32'(mem_wr_burst_req), 32'(ew));
      chk("mem_rd_req", 32'(mem_rd_burst_req), 32'(er));
      chk("wr_finish", 32'(wr_finish),
          32'((m_owner == 1) && (m_local_fin || (ew && mem_wr_burst_finish))));
      chk("rd_finish", 32'(rd_finish),
          32'((m_owner == 2) && (m_local_fin || (er && mem_rd_burst_finish))));
      chk("wr_data_req", 32'(wr_data_req), 32'(mem_wr_burst_data_req && m_owner == 1));
      chk("rd_data_valid", 32'(rd_data_valid), 32'(mem_rd_burst_data_valid && m_owner == 2));
      chk("rd_data", 32'(rd_data), 32'(mem_rd_burst_data));
      chk("mem_wr_data", 32'(mem_wr_burst_data), 32'(wr_data));
      if (ew) begin
        chk("mem_wr_len", 32'(mem_wr_burst_len), 32'(m_len));
        chk("mem_wr_addr", 32'(mem_wr_burst_addr), 32'(m_addr));
      end
      if (er) begin
        chk("mem_rd_len", 32'(mem_rd_burst_len), 32'(m_len));
        chk("mem_rd_addr", 32'(mem_rd_burst_addr), 32'(m_addr));
      end
    end
  end

  // ---------------- memory-controller stub ----------------
  int  wbeats = 0, rbeats = 0;
  bit  wdone = 1'b0, rdone = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      mem_wr_burst_data_req   = 1'b0;
      mem_wr_burst_finish     = force_wfin;
      mem_rd_burst_data_valid = 1'b0;
      mem_rd_burst_finish     = 1'b0;
      mem_rd_burst_data       = DW'($urandom);
      if (mem_wr_burst_req && !wdone) begin
        if (wbeats < int'(mem_wr_burst_len)) begin
          if ($urandom_range(3) != 0) begin mem_wr_burst_data_req = 1'b1; wbeats++; end
        end else begin
          mem_wr_burst_finish = 1'b1; wdone = 1'b1;
        end
      end else if (!mem_wr_burst_req) begin
        wbeats = 0; wdone = 1'b0;
        if ($urandom_range(15) == 0) mem_wr_burst_finish = 1'b1;
        if ($urandom_range(7) == 0) mem_wr_burst_data_req = 1'b1;
      end
      if (mem_rd_burst_req && !rdone) begin
        if (rbeats < int'(mem_rd_burst_len)) begin
          if ($urandom_range(3) != 0) begin mem_rd_burst_data_valid = 1'b1; rbeats++; end
        end else begin
          mem_rd_burst_finish = 1'b1; rdone = 1'b1;
        end
      end else if (!mem_rd_burst_req) begin
        rbeats = 0; rdone = 1'b0;
        if ($urandom_range(15) == 0) mem_rd_burst_finish = 1'b1;
        if ($urandom_range(7) == 0) mem_rd_burst_data_valid = 1'b1;
      end
    end
  end

  // Random write data on every cycle
  initial forever begin @(posedge clk); #1; wr_data = DW'($urandom); end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (grant == 2'b00) break;
    end
    chk({name, "_idle_timeout"}, 32'(i >= 2000), 32'd0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int strobes, fins, fin_at, k, cnt;
    bit saw, done;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_wreq", 32'(mem_wr_burst_req), 32'd0);
    chk("rst_rreq", 32'(mem_rd_burst_req), 32'd0);
    chk("rst_len", 32'(mem_wr_burst_len), 32'd0);
    chk("rst_addr", 32'(mem_rd_burst_addr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Write-only 256-beat burst
    @(posedge clk); #1;
    wr_req = 1'b1; wr_len = 10'd256; wr_addr = 24'h000100;
    @(posedge clk); #1;
    chk("w37_grant", 32'(grant), 32'd1);
    chk("w37_req", 32'(mem_wr_burst_req), 32'd1);
    chk("w37_len", 32'(mem_wr_burst_len), 32'd256);
    chk("w37_addr", 32'(mem_wr_burst_addr), 32'h100);
    wr_req = 1'b0;
    strobes = 0; fins = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      strobes += int'(wr_data_req); fins += int'(wr_finish);
      if (grant == 2'b00) break;
    end
    chk("w37_strobes", 32'(strobes), 32'd256);
    chk("w37_finish", 32'(fins), 32'd1);
    chk("w37_end_idle", 32'(grant), 32'd0);

    // Zero-length read: finishes two cycles after the request
    @(posedge clk); #1;
    rd_req = 1'b1; rd_len = '0; rd_addr = 24'h00beef;
    fin_at = -1; saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_finish) fin_at = i;
      if (mem_rd_burst_req) saw = 1'b1;
      if (i == 1) rd_req = 1'b0;
    end
    chk("r40_fin_cycle", 32'(fin_at), 32'd2);
    chk("r40_no_req", 32'(saw), 32'd0);
    chk("r40_grant_end", 32'(grant), 32'd0);

    // Simultaneous requests: read first, write one idle cycle after rd_finish
    @(posedge clk); #1;
    wr_req = 1'b1; wr_len = 10'd3; wr_addr = 24'h000a00;
    rd_req = 1'b1; rd_len = 10'd2; rd_addr = 24'h000b00;
    k = -10; done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 1) begin chk("t38_first", 32'(grant), 32'd2); rd_req = 1'b0; end
      if (rd_finish) k = i;
      if (i == k + 1) chk("t38_gap", 32'(grant), 32'd0);
      if (i == k + 2) begin chk("t38_second", 32'(grant), 32'd1); wr_req = 1'b0; end
      if (wr_finish) begin done = 1'b1; break; end
    end
    chk("t38_done", 32'(done), 32'd1);
    wait_idle("t38");

    // Spurious write finish during a read burst
    @(posedge clk); #1;
    rd_req = 1'b1; rd_len = 10'd6; rd_addr = 24'h000c00;
    @(posedge clk); #1;
    rd_req = 1'b0; force_wfin = 1'b1;
    @(negedge clk);
    chk("t42_wr_finish", 32'(wr_finish), 32'd0);
    chk("t42_grant", 32'(grant), 32'd2);
    @(posedge clk); #1 force_wfin = 1'b0;
    @(negedge clk);
    chk("t42_rd_req_kept", 32'(mem_rd_burst_req), 32'd1);
    fins = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      fins += int'(rd_finish);
      if (grant == 2'b00) break;
    end
    chk("t42_rd_finish", 32'(fins), 32'd1);

    // Reset midway through a 512-beat read
    @(posedge clk); #1;
    rd_req = 1'b1; rd_len = 10'd512; rd_addr = 24'h00abcd;
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (200) @(negedge clk);
    chk("t41_in_burst", 32'(mem_rd_burst_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t41_grant", 32'(grant), 32'd0);
    chk("t41_rreq", 32'(mem_rd_burst_req), 32'd0);
    chk("t41_len", 32'(mem_rd_burst_len), 32'd0);
    chk("t41_addr", 32'(mem_rd_burst_addr), 32'd0);
    fins = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); fins += int'(rd_finish);
    end
    chk("t41_no_finish", 32'(fins), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_len = 10'd4; wr_addr = 24'h000040;
    @(negedge clk);
    @(negedge clk);
    chk("t41_wr_after", 32'(grant), 32'd1);
    wr_req = 1'b0;
    wait_idle("t41");

`ifdef ARB_STARVE_GUARD_EN
    // Continuous reads must not starve a waiting write forever
    @(posedge clk); #1;
    rd_req = 1'b1; rd_len = 10'd2; rd_addr = 24'h000d00;
    wr_req = 1'b1; wr_len = 10'd1; wr_addr = 24'h000e00;
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant == 2'b10) cnt++;
      if (grant == 2'b01) begin done = 1'b1; break; end
    end
    chk("t39_wr_granted", 32'(done), 32'd1);
    chk("t39_after_reads", 32'(cnt > 0), 32'd1);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_idle("t39");
`endif

    // Random traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(3) == 0) begin
        wr_req  = ($urandom_range(1) == 1);
        wr_len  = LW'($urandom_range(6));
        wr_addr = AW'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        rd_req  = ($urandom_range(1) == 1);
        rd_len  = LW'($urandom_range(6));
        rd_addr = AW'($urandom);
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
